// File: rtl/spi_register_write_fifo_pkg.sv
// Shared types and helpers for the SPI write-direction register.
// Holds the transaction FSM encoding and the byte-count saturation limit.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, RECEIVE, DROP, DONE} spi_write_state_t;

    localparam int SPI_LENGTH_MAX = 255;

    function automatic logic [7:0] sat_increment(input logic [7:0] value);
        return (value == 8'(SPI_LENGTH_MAX)) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/spi_register_write_fifo_if.sv
// Byte-stream and status bundle between the SPI register decoder, the
// write register, and the fabric-side consumer.
interface spi_register_write_fifo_if;

    logic       enable;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_ready;
    logic       transaction_done;
    logic [7:0] last_length;
    logic       overflow;

    modport master (
        output enable, data_in, data_in_valid, fifo_ready,
        input  fifo_data, fifo_valid, transaction_done, last_length, overflow
    );

    modport slave (
        input  enable, data_in, data_in_valid, fifo_ready,
        output fifo_data, fifo_valid, transaction_done, last_length, overflow
    );

endinterface

// File: rtl/spi_register_write_fifo_byte_fifo.sv
// Register-based show-ahead byte FIFO. A push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module spi_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0] ONE = 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty gates the read path until a byte lands.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_register_write_fifo.sv
// Write-direction SPI register: captures host bytes of a selected transaction
// into a FIFO and reports per-transaction length, completion and overflow.
module spi_register_write_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    spi_register_write_fifo_if.slave bus
);

    import spi_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    spi_write_state_t state;
    spi_write_state_t state_next;

    logic          enable_q;
    logic          rise;
    logic          strobe;
    logic          pop_now;
    logic          space;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [7:0]    run_count;
    logic [7:0]    run_count_next;
    logic [7:0]    last_length_q;
    logic [7:0]    last_length_next;
    logic          overflow_q;
    logic          overflow_next;

    assign rise    = bus.enable && !enable_q;
    assign strobe  = bus.enable && bus.data_in_valid;
    assign pop_now = bus.fifo_ready && !fifo_empty;
    assign space   = !fifo_full || pop_now;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.data_in),
        .pop       (bus.fifo_ready),
        .pop_data  (bus.fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.fifo_valid       = (fifo_count != '0);
    assign bus.transaction_done = (state == DONE);
    assign bus.last_length      = last_length_q;
    assign bus.overflow         = overflow_q;

    // enable_q resets high so an enable already asserted at reset release is
    // not mistaken for a fresh transaction start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_q      <= 1'b1;
            state         <= IDLE;
            run_count     <= '0;
            last_length_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            enable_q      <= bus.enable;
            state         <= state_next;
            run_count     <= run_count_next;
            last_length_q <= last_length_next;
            overflow_q    <= overflow_next;
        end
    end

    // The end of a transaction is seen one cycle late through enable_q, which
    // is why strobes are also qualified by the live enable.
    always_comb begin
        state_next       = state;
        run_count_next   = run_count;
        last_length_next = last_length_q;
        overflow_next    = overflow_q;
        push             = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next     = RECEIVE;
                    run_count_next = '0;
                    overflow_next  = 1'b0;
                    if (strobe) begin
                        run_count_next = 8'd1;
                        if (space) begin
                            push = 1'b1;
                        end else begin
                            overflow_next = 1'b1;
                            state_next    = DROP;
                        end
                    end
                end
            end
            RECEIVE: begin
                if (!enable_q) begin
                    state_next       = DONE;
                    last_length_next = run_count;
                end else if (strobe) begin
                    run_count_next = sat_increment(run_count);
                    if (space) begin
                        push = 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                        state_next    = DROP;
                    end
                end
            end
            DROP: begin
                if (!enable_q) begin
                    state_next       = DONE;
                    last_length_next = run_count;
                end else if (strobe) begin
                    run_count_next = sat_increment(run_count);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_register_write_fifo.sv
// Self-checking bench for spi_register_write_fifo: directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_spi_register_write_fifo;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    spi_register_write_fifo_if bus ();

    spi_register_write_fifo #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference: byte queue plus a few status flags.
    byte unsigned m_q[$];
    byte unsigned drained[$];
    bit m_in_txn, m_dropping, m_ovf, m_prev_en, m_pend, m_done;
    int m_cnt, m_pend_len, m_len;

    typedef struct {
        bit           en;
        bit           val;
        byte unsigned d;
        bit           rdy;
        bit           e_valid;
        byte unsigned e_data;
        bit           e_done;
        byte unsigned e_len;
        bit           e_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_txn   = 1'b0;
        m_dropping = 1'b0;
        m_ovf      = 1'b0;
        m_prev_en  = 1'b1;
        m_pend     = 1'b0;
        m_done     = 1'b0;
        m_cnt      = 0;
        m_pend_len = 0;
        m_len      = 0;
    endtask

    task automatic model_edge();
        bit en, pop_ok, space, start, strobe;
        en     = bus.enable;
        pop_ok = bus.fifo_ready && (m_q.size() > 0);
        space  = (m_q.size() < DEPTH) || pop_ok;
        m_done = m_pend;
        if (m_pend) m_len = m_pend_len;
        m_pend = 1'b0;
        start  = en && !m_prev_en && !m_in_txn;
        if (start) begin
            m_in_txn   = 1'b1;
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_dropping = 1'b0;
        end else if (m_in_txn && !en) begin
            m_in_txn   = 1'b0;
            m_pend     = 1'b1;
            m_pend_len = m_cnt;
        end
        strobe = m_in_txn && en && bus.data_in_valid;
        if (pop_ok) void'(m_q.pop_front());
        if (strobe) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_dropping) begin
                if (space) begin
                    m_q.push_back(bus.data_in);
                end else begin
                    m_dropping = 1'b1;
                    m_ovf      = 1'b1;
                end
            end
        end
        m_prev_en = en;
    endtask

    task automatic check_output(input string tag);
        chk({tag, " fifo_valid"}, bus.fifo_valid, (m_q.size() > 0) ? 1 : 0);
        chk({tag, " fifo_data"}, bus.fifo_data, (m_q.size() > 0) ? m_q[0] : 0);
        chk({tag, " transaction_done"}, bus.transaction_done, m_done);
        chk({tag, " last_length"}, bus.last_length, m_len);
        chk({tag, " overflow"}, bus.overflow, m_ovf);
    endtask

    task automatic apply_stimulus(input bit en, input bit val, input byte unsigned d, input bit rdy);
        bus.enable        = en;
        bus.data_in_valid = val;
        bus.data_in       = d;
        bus.fifo_ready    = rdy;
    endtask

    task automatic tick(input string tag, input bit use_model);
        if (bus.fifo_valid && bus.fifo_ready) drained.push_back(bus.fifo_data);
        @(posedge clock);
        if (reset_n) model_edge();
        else model_reset();
        @(negedge clock);
        if (use_model) check_output(tag);
    endtask

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h54, 1'b1, 1'b1, 8'h54, 1'b0, 8'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h65, 1'b1, 1'b1, 8'h65, 1'b0, 8'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h73, 1'b1, 1'b1, 8'h73, 1'b0, 8'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h74, 1'b1, 1'b1, 8'h74, 1'b0, 8'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'd4, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4, 1'b0};

        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        #2;
        chk("reset fifo_valid", bus.fifo_valid, 0);
        chk("reset fifo_data", bus.fifo_data, 0);
        chk("reset transaction_done", bus.transaction_done, 0);
        chk("reset last_length", bus.last_length, 0);
        chk("reset overflow", bus.overflow, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick("idle", 1'b1);
        tick("idle", 1'b1);

        // Directed 4-byte write, compared against the hand-derived table.
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].val, vecs[i].d, vecs[i].rdy);
            tick("table", 1'b0);
            chk($sformatf("table[%0d] fifo_valid", i), bus.fifo_valid, vecs[i].e_valid);
            chk($sformatf("table[%0d] fifo_data", i), bus.fifo_data, vecs[i].e_data);
            chk($sformatf("table[%0d] transaction_done", i), bus.transaction_done, vecs[i].e_done);
            chk($sformatf("table[%0d] last_length", i), bus.last_length, vecs[i].e_len);
            chk($sformatf("table[%0d] overflow", i), bus.overflow, vecs[i].e_ovf);
        end

        // 18 bytes into a 16-deep FIFO with the consumer stalled.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick("gap", 1'b1);
        tick("gap", 1'b1);
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(i), 1'b0);
            tick("ovf", 1'b1);
            if (i == 15) chk("ovf before 17th", bus.overflow, 0);
            if (i == 16) chk("ovf after 17th", bus.overflow, 1);
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick("ovf end", 1'b1);
        tick("ovf end", 1'b1);
        chk("ovf done pulse", bus.transaction_done, 1);
        chk("ovf last_length", bus.last_length, 18);
        drained.delete();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovf drain[%0d]", k), bus.fifo_data, k);
            tick("ovf drain", 1'b1);
        end
        chk("ovf drain empty", bus.fifo_valid, 0);
        chk("ovf drain count", drained.size(), 16);

        // Full FIFO with a pop on the same cycle as a strobe.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick("gap", 1'b1);
        tick("gap", 1'b1);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
            tick("fill", 1'b1);
        end
        apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b1);
        tick("full pop push", 1'b1);
        chk("full pop push count", dut.u_fifo.count, 16);
        chk("full pop push overflow", bus.overflow, 0);
        chk("full pop push head", bus.fifo_data, 8'h21);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) tick("full end", 1'b1);
        drained.delete();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (20) tick("full drain", 1'b1);
        chk("full drain count", drained.size(), 16);
        chk("full drain last", (drained.size() == 16) ? drained[15] : 0, 8'hA5);

        // Overflow, then space frees while still in the transaction.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick("gap", 1'b1);
        drained.delete();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
            tick("drop fill", 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(8'hC0 + i), 1'b1);
            tick("drop space", 1'b1);
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (20) tick("drop drain", 1'b1);
        chk("drop drain count", drained.size(), 16);
        chk("drop drain last", (drained.size() == 16) ? drained[15] : 0, 8'h4F);
        chk("drop overflow sticky", bus.overflow, 1);
        chk("drop last_length", bus.last_length, 21);
        apply_stimulus(1'b1, 1'b1, 8'h99, 1'b0);
        tick("drop next txn", 1'b1);
        chk("next txn overflow cleared", bus.overflow, 0);
        chk("next txn stored", bus.fifo_data, 8'h99);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (4) tick("drop next end", 1'b1);

        // Strobes with enable low, and one on the falling-edge cycle.
        repeat (3) begin
            apply_stimulus(1'b0, 1'b1, 8'h11, 1'b0);
            tick("enable low", 1'b1);
        end
        chk("enable low no push", bus.fifo_valid, 0);
        apply_stimulus(1'b1, 1'b1, 8'h31, 1'b0);
        tick("fall", 1'b1);
        apply_stimulus(1'b1, 1'b1, 8'h32, 1'b0);
        tick("fall", 1'b1);
        apply_stimulus(1'b0, 1'b1, 8'h33, 1'b0);
        tick("fall", 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick("fall", 1'b1);
        chk("fall done pulse", bus.transaction_done, 1);
        chk("fall last_length", bus.last_length, 2);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (4) tick("fall drain", 1'b1);

        // Reset in the middle of an 8-byte transaction with enable held high.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(8'h61 + i), 1'b0);
            tick("pre reset", 1'b1);
        end
        reset_n = 1'b0;
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        model_reset();
        chk("mid reset fifo_valid", bus.fifo_valid, 0);
        chk("mid reset fifo_data", bus.fifo_data, 0);
        chk("mid reset last_length", bus.last_length, 0);
        chk("mid reset overflow", bus.overflow, 0);
        tick("in reset", 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(8'h70 + i), 1'b0);
            tick("post reset", 1'b1);
            chk("post reset ignored", bus.fifo_valid, 0);
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) tick("post reset idle", 1'b1);
        apply_stimulus(1'b1, 1'b1, 8'h7E, 1'b0);
        tick("post reset txn", 1'b1);
        chk("post reset txn head", bus.fifo_data, 8'h7E);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) tick("post reset end", 1'b1);
        chk("post reset last_length", bus.last_length, 1);

        // Random transactions with random consumer back-pressure.
        for (int t = 0; t < 40; t++) begin
            int gap_len, txn_len;
            gap_len = $urandom_range(3, 6);
            txn_len = $urandom_range(1, 24);
            for (int g = 0; g < gap_len; g++) begin
                apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
                tick("rand gap", 1'b1);
            end
            for (int c = 0; c < txn_len; c++) begin
                apply_stimulus(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0));
                tick("rand txn", 1'b1);
            end
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (24) tick("rand drain", 1'b1);
        chk("final empty", bus.fifo_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_register_write_fifo.md
# spi_register_write_fifo

Write-direction SPI register: collects bytes written by the host during a selected SPI register transaction and hands them to internal fabric logic through a valid/ready byte stream. It sits behind the SPI subperipheral's register decoder, opposite to the read-only register responders. It also reports per-transaction status: byte count, completion pulse and sticky overflow.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in bytes. Must be a power of two, 4 to 256.

Ports (`name  direction  width  meaning`):
- clock  input  1  single system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  register selected by the decoder. High for the whole transaction; the rising edge starts a transaction and the falling edge ends it.
- data_in  input  8  byte written by the host.
- data_in_valid  input  1  one-cycle strobe per received byte. Ignored while enable is low.
- fifo_data  output  8  head-of-FIFO byte (show-ahead).
- fifo_valid  output  1  FIFO non-empty.
- fifo_ready  input  1  consumer pops the head byte when fifo_valid and fifo_ready are both high.
- transaction_done  output  1  one-cycle pulse after each transaction ends.
- last_length  output  8  bytes received in the last completed transaction, including dropped bytes; saturates at 255.
- overflow  output  1  sticky: a byte was dropped in the current or last transaction.

## Operation
- Reset values: fifo_valid=0, fifo_data=0, transaction_done=0, last_length=0, overflow=0. State is IDLE, pointers and count are 0, FIFO is empty.
- enable is sampled into a 1-bit register, enable_q; edges are detected against it.
- FSM states and transitions:
  - IDLE → RECEIVE on an enable rising edge. This also clears overflow and the running byte counter. FIFO contents are not flushed.
  - RECEIVE: each data_in_valid increments the running counter (saturating at 255) and pushes data_in if space is available. If there is no space, the byte is dropped, overflow is set and the FSM moves to DROP.
  - DROP: further bytes are counted but never pushed, even if space frees up. This keeps the stored stream a clean prefix of the transaction.
  - RECEIVE/DROP → DONE on an enable falling edge. last_length takes the running count.
  - DONE → IDLE after one cycle. transaction_done is high only while in DONE.
- Space rule: a push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pops are independent of the FSM and are allowed in every state. A pop while empty is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- A data_in_valid arriving in the same cycle as the enable rising edge is counted and pushed in that transaction.
- A data_in_valid arriving in the same cycle as the enable falling edge is ignored.
- reset_n asserted mid-transaction returns everything to reset values; the FIFO is emptied. After release, the FSM waits for a fresh enable rising edge, even if enable is already high.

## Timing
- Push latency: a byte strobed in cycle N appears on fifo_data with fifo_valid=1 in cycle N+1 if the FIFO was empty.
- fifo_data is read combinationally from mem[rd_ptr] and is 0 when empty.
- transaction_done pulses in cycle N+2 when enable falls in cycle N (edge detected at N+1; DONE at N+2). last_length is valid in the same cycle as the pulse.
- overflow rises in the cycle after the dropping strobe.
- Back-to-back data_in_valid on every cycle is supported; the sustained rate is one byte per cycle in each direction.

## Structure
- Shared package spi_pkg holds:
  - typedef enum logic [1:0] {IDLE, RECEIVE, DROP, DONE} spi_write_state_t
  - localparam SPI_LENGTH_MAX = 255
- Sub-module spi_byte_fifo (parameter DEPTH):
  - ports: clock, reset_n, push, push_data, pop, pop_data, empty, full, count
  - uses register-based storage and implements the space rule above
- The top level holds the FSM, edge detect, counters and status outputs.

## Test plan
- Write 4 bytes 0x54,0x65,0x73,0x74 with fifo_ready=1 → fifo_data emits them in order, each one cycle after its strobe; transaction_done pulses 2 cycles after enable falls; last_length=4; overflow=0.
- DEPTH=16, fifo_ready=0, 18 bytes 0x00..0x11 → FIFO holds 0x00..0x0F; overflow=1 from the cycle after the 17th strobe; last_length=18. Draining then yields exactly 16 bytes.
- FIFO full, fifo_ready=1 on the same cycle as a strobe of 0xA5 → push accepted, count stays 16, overflow=0, and 0xA5 emerges last.
- Overflow then space frees mid-transaction (DROP state) → later bytes are not stored. The next transaction's rising edge clears overflow, and its bytes are stored again.
- data_in_valid pulses with enable low, and one strobe on the enable falling-edge cycle → nothing pushed, not counted.
- reset_n low for one cycle after 3 bytes of an 8-byte transaction, with enable held high → all outputs 0, FIFO empty; the remaining 5 strobes are ignored until enable toggles.
